// File: rtl/relu_maxpool_2x2.sv
// ReLU, 2x2 stride-2 max pooling and requantization to signed 16-bit for a raster-order
// conv result stream. Gaps in in_valid are allowed and there is no backpressure.
module relu_maxpool_2x2 #(
   parameter int unsigned IMG_W = 24,
   parameter int unsigned IMG_H = 24,
   parameter int unsigned SHIFT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [32:0] data_in,
   input  logic               in_valid,
   output logic               out_valid,
   output logic signed [15:0] data_out,
   output logic               frame_done
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int unsigned LB_N   = IMG_W / 2;
   localparam int unsigned LB_W   = (LB_N > 1) ? $clog2(LB_N) : 1;

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DATA_W-1:0] h_q, h_d;
   logic [DATA_W-1:0] lb_q [LB_N];
   logic [DATA_W-1:0] lb_d [LB_N];
   logic              out_valid_q, out_valid_d;
   logic signed [15:0] data_out_q, data_out_d;
   logic              frame_done_q, frame_done_d;

   logic [DATA_W-1:0] relu_c;
   logic [DATA_W-1:0] hm_c;
   logic [DATA_W-1:0] lb_rd_c;
   logic [DATA_W-1:0] pool_c;
   logic [DATA_W-1:0] shifted_c;
   logic [LB_W-1:0]   lb_idx_c;
   logic              last_col_c;
   logic              last_row_c;

   // Datapath: ReLU, horizontal max, vertical max and saturating requantize.
   always_comb begin
      relu_c     = data_in[32] ? '0 : data_in[DATA_W-1:0];
      hm_c       = (h_q > relu_c) ? h_q : relu_c;
      lb_idx_c   = LB_W'(col_q >> 1);
      lb_rd_c    = lb_q[lb_idx_c];
      pool_c     = (lb_rd_c > hm_c) ? lb_rd_c : hm_c;
      shifted_c  = pool_c >> SHIFT;
      last_col_c = (col_q == COL_W'(IMG_W - 1));
      last_row_c = (row_q == ROW_W'(IMG_H - 1));
   end

   // Next-state: counters, horizontal register, line buffer and output register.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      h_d          = h_q;
      lb_d         = lb_q;
      out_valid_d  = 1'b0;
      data_out_d   = '0;
      frame_done_d = 1'b0;

      if (in_valid) begin
         if (!col_q[0]) begin
            h_d = relu_c;
         end else if (!row_q[0]) begin
            lb_d[lb_idx_c] = hm_c;
         end else begin
            out_valid_d  = 1'b1;
            data_out_d   = (shifted_c > DATA_W'(32767)) ? 16'sd32767 : $signed(shifted_c[15:0]);
            frame_done_d = last_col_c && last_row_c;
         end

         if (last_col_c) begin
            col_d = '0;
            row_d = last_row_c ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         h_q          <= '0;
         out_valid_q  <= 1'b0;
         data_out_q   <= '0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < int'(LB_N); i++) begin
            lb_q[i] <= '0;
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         h_q          <= h_d;
         out_valid_q  <= out_valid_d;
         data_out_q   <= data_out_d;
         frame_done_q <= frame_done_d;
         for (int i = 0; i < int'(LB_N); i++) begin
            lb_q[i] <= lb_d[i];
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign data_out   = data_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Self-checking bench for relu_maxpool_2x2: directed frames plus random frames, checked
// cycle by cycle against a frame-array pooling model, with SHIFT=0 and SHIFT=4 instances.
module tb_relu_maxpool_2x2;

   localparam int W = 24;
   localparam int H = 24;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [32:0] data_in = '0;
   logic               in_valid = 1'b0;
   logic               ov0, fd0, ov4, fd4;
   logic signed [15:0] do0, do4;

   always #5 clk = ~clk;

   relu_maxpool_2x2 #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
      .out_valid(ov0), .data_out(do0), .frame_done(fd0));

   relu_maxpool_2x2 #(.IMG_W(W), .IMG_H(H), .SHIFT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
      .out_valid(ov4), .data_out(do4), .frame_done(fd4));

   int     n_chk = 0;
   int     n_pass = 0;
   longint frame [H][W];
   int     pix = 0;
   bit     exp_v = 0;
   bit     exp_fd = 0;
   longint exp0 = 0;
   longint exp4 = 0;
   longint got0_q[$];
   longint got4_q[$];
   int     fd_cnt = 0;
   int     picks [W/2];

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic longint relu(input longint v);
      return (v < 0) ? 0 : v;
   endfunction

   function automatic longint requant(input longint p, input int sh);
      longint y;
      y = p >> sh;
      return (y > 32767) ? 32767 : y;
   endfunction

   // Compare both instances against what the previous cycle's input should produce.
   task automatic observe();
      check("out_valid_s0", longint'(ov0), longint'(exp_v));
      check("data_out_s0", longint'(do0), exp_v ? exp0 : 0);
      check("frame_done_s0", longint'(fd0), longint'(exp_v && exp_fd));
      check("out_valid_s4", longint'(ov4), longint'(exp_v));
      check("data_out_s4", longint'(do4), exp_v ? exp4 : 0);
      check("frame_done_s4", longint'(fd4), longint'(exp_v && exp_fd));
      if (ov0) begin
         got0_q.push_back(longint'(do0));
         if (fd0) fd_cnt++;
      end
      if (ov4) got4_q.push_back(longint'(do4));
   endtask

   task automatic step(input bit v, input longint val);
      int r;
      int c;
      longint m;
      @(negedge clk);
      observe();
      in_valid = v;
      data_in  = v ? 33'(val) : '0;
      exp_v  = 0;
      exp_fd = 0;
      if (v) begin
         r = pix / W;
         c = pix % W;
         frame[r][c] = val;
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = relu(frame[r-1][c-1]);
            if (relu(frame[r-1][c]) > m) m = relu(frame[r-1][c]);
            if (relu(frame[r][c-1]) > m) m = relu(frame[r][c-1]);
            if (relu(frame[r][c]) > m) m = relu(frame[r][c]);
            exp_v  = 1;
            exp0   = requant(m, 0);
            exp4   = requant(m, 4);
            exp_fd = (pix == W*H - 1);
         end
         pix = (pix + 1) % (W*H);
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      observe();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = '0;
      exp_v    = 0;
      pix      = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         observe();
      end
      rst_n = 1'b1;
   endtask

   // mode: 0 ramp+offset, 1 constant offset, 2 one -2^32 per window else 5,
   //       3 window {7,3,9,1} at (0,0) else 0, 4 random
   function automatic longint pix_val(input int mode, input int r, input int c, input longint off);
      longint v;
      case (mode)
         0: v = longint'(r*W + c) + off;
         1: v = off;
         2: v = (picks[c/2] == (r%2)*2 + (c%2)) ? -(longint'(1) << 32) : 5;
         3: begin
            if (r == 0 && c == 0) v = 7;
            else if (r == 0 && c == 1) v = 3;
            else if (r == 1 && c == 0) v = 9;
            else if (r == 1 && c == 1) v = 1;
            else v = 0;
         end
         default: begin
            case ($urandom_range(0, 2))
               0: v = longint'($urandom_range(0, 200000)) - 100000;
               1: v = longint'($urandom_range(0, 600000));
               default: v = longint'($signed({1'b0, $urandom})) - (longint'($urandom_range(0, 1)) << 32);
            endcase
         end
      endcase
      return v;
   endfunction

   task automatic send_frame(input int mode, input longint off, input bit gapped, input int max_pix);
      int n;
      n = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (n >= max_pix) return;
            if (r % 2 == 0 && c % 2 == 0) picks[c/2] = int'($urandom_range(0, 3));
            step(1'b1, pix_val(mode, r, c, off));
            n++;
            if (gapped && ($urandom_range(0, 5) == 0)) begin
               repeat ($urandom_range(1, 3)) step(1'b0, 0);
            end
         end
         if (gapped) repeat (4) step(1'b0, 0);
      end
   endtask

   task automatic start_collect();
      got0_q.delete();
      got4_q.delete();
      fd_cnt = 0;
   endtask

   task automatic flush();
      repeat (3) step(1'b0, 0);
   endtask

   task automatic check_ramp(input string tag, input int base, input longint off);
      for (int i = 0; i < H/2; i++) begin
         for (int j = 0; j < W/2; j++) begin
            if (base + i*(W/2) + j < got0_q.size())
               check(tag, got0_q[base + i*(W/2) + j], longint'((2*i+1)*W + 2*j + 1) + off);
         end
      end
   endtask

   initial begin
      // reset state
      do_reset(3);
      check("reset_out_valid", longint'(ov0), 0);
      check("reset_data_out", longint'(do0), 0);

      // 1: ramp, continuous
      start_collect();
      send_frame(0, 0, 1'b0, W*H);
      flush();
      check("ramp_count", got0_q.size(), 144);
      check("ramp_frame_done", fd_cnt, 1);
      if (got0_q.size() == 144) begin
         check("ramp_first", got0_q[0], 25);
         check("ramp_last", got0_q[143], 575);
      end
      check_ramp("ramp_px", 0, 0);

      // 2: all negative, then one -2^32 per window
      start_collect();
      send_frame(1, -33, 1'b0, W*H);
      flush();
      check("neg_count", got0_q.size(), 144);
      foreach (got0_q[k]) check("neg_px", got0_q[k], 0);
      start_collect();
      send_frame(2, 0, 1'b0, W*H);
      flush();
      check("negwin_count", got0_q.size(), 144);
      foreach (got0_q[k]) check("negwin_px", got0_q[k], 5);

      // 3: saturation and shift
      start_collect();
      send_frame(1, 100000, 1'b0, W*H);
      flush();
      check("sat_count", got0_q.size(), 144);
      foreach (got0_q[k]) check("sat_px", got0_q[k], 32767);
      foreach (got4_q[k]) check("shift4_px", got4_q[k], 6250);
      start_collect();
      send_frame(3, 0, 1'b0, W*H);
      flush();
      if (got0_q.size() > 0) check("window_7391", got0_q[0], 9);
      else check("window_7391_count", got0_q.size(), 144);

      // 4: gapped ramp
      start_collect();
      send_frame(0, 0, 1'b1, W*H);
      flush();
      check("gap_count", got0_q.size(), 144);
      check_ramp("gap_px", 0, 0);

      // 5: mid-frame reset
      send_frame(0, 0, 1'b0, 300);
      do_reset(4);
      start_collect();
      send_frame(0, 0, 1'b0, W*H);
      flush();
      check("rst_count", got0_q.size(), 144);
      check_ramp("rst_px", 0, 0);

      // 6: back-to-back frames
      start_collect();
      send_frame(0, 0, 1'b0, W*H);
      send_frame(0, 1000, 1'b0, W*H);
      flush();
      check("b2b_count", got0_q.size(), 288);
      check("b2b_frame_done", fd_cnt, 2);
      check_ramp("b2b_px0", 0, 0);
      check_ramp("b2b_px1", 144, 1000);

      // random frames, some gapped
      for (int f = 0; f < 3; f++) begin
         start_collect();
         send_frame(4, 0, f[0], W*H);
         flush();
         check("rand_count", got0_q.size(), 144);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
